run_step_ctrl: RTL and testbench

//  Upstream control stage for the CPU clock divider: debounces the board RUN/STOP and STEP

---
 rtl/run_step_ctrl.sv | 110 +++++++++++
 tb/tb_run_step_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_step_ctrl.sv
// Debounces RUN/STOP and STEP buttons and drives the CPU divider's stop input (free-run, halt, single-step).
// Raw button edge to stop/halted change: 3 + DEBOUNCE_CYCLES clk_board cycles; presses are strobes.
module run_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit START_HALTED    = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk_board,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             clk_cpu,
    output logic             stop,
    output logic             halted,
    output logic [CNT_W-1:0] step_cnt
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_RST  = START_HALTED ? ST_HALT : ST_RUN;

    // bit 0 = RUN/STOP button, bit 1 = STEP button
    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q, sync2_q, level_q, press_q;
    logic [1:0][DB_W-1:0] db_cnt_q;

    assign btn_raw = {btn_step, btn_run};

    // A new level must differ from the accepted one for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    press_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic             run_press, step_press, cpu_rise, cnt_inc;
    logic             clk_cpu_q, stop_q, halted_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q;

    assign run_press  = press_q[0];
    assign step_press = press_q[1];
    assign cpu_rise   = clk_cpu & ~clk_cpu_q;

    // run_press beats both step_press and cpu_rise when they coincide.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run_press) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (run_press)       state_d = ST_RUN;
                else if (step_press) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (cpu_rise) begin
                    state_d = ST_HALT;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            stop_q     <= START_HALTED;
            halted_q   <= START_HALTED;
            step_cnt_q <= '0;
            clk_cpu_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_q    <= (state_d == ST_HALT);
            halted_q  <= (state_d == ST_HALT);
            clk_cpu_q <= clk_cpu;
            if (cnt_inc) step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign stop     = stop_q;
    assign halted   = halted_q;
    assign step_cnt = step_cnt_q;
endmodule

// File: tb/tb_run_step_ctrl.sv
// Bench for run_step_ctrl: behavioural divider on clk_cpu, randomized bouncy presses, mode/step model.
module tb_run_step_ctrl;
    localparam int DC = 4;
    localparam int M_RUN = 0;
    localparam int M_HALT = 1;

    logic        clk_board = 1'b0;
    logic        rst_n;
    logic        btn_run, btn_step;
    logic        clk_cpu;
    logic        stop, halted;
    logic [15:0] step_cnt;
    logic        stop_w, halted_w;
    logic [1:0]  step_cnt_w;

    int checks = 0;
    int errors = 0;
    int div_cnt;
    int cpu_pos = 0;
    int m_mode;
    int m_cnt;

    run_step_ctrl #(.DEBOUNCE_CYCLES(DC), .START_HALTED(1'b1), .CNT_W(16)) dut (
        .clk_board(clk_board), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .clk_cpu(clk_cpu), .stop(stop), .halted(halted), .step_cnt(step_cnt)
    );

    // Narrow counter instance sharing all inputs: shows the wrap from all-ones to zero.
    run_step_ctrl #(.DEBOUNCE_CYCLES(DC), .START_HALTED(1'b1), .CNT_W(2)) dut_w (
        .clk_board(clk_board), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
        .clk_cpu(clk_cpu), .stop(stop_w), .halted(halted_w), .step_cnt(step_cnt_w)
    );

    always #5 clk_board = ~clk_board;

    always @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 0;
            clk_cpu <= 1'b0;
        end else if (!stop) begin
            if (div_cnt == 5) begin
                div_cnt <= 0;
                clk_cpu <= ~clk_cpu;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    always @(posedge clk_cpu) cpu_pos <= cpu_pos + 1;

    task automatic tick();
        @(posedge clk_board);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Bounce pulses stay shorter than DC, then the level settles high and stays held.
    task automatic drive_press(input bit r, input bit s, input int nb);
        for (int i = 0; i < nb; i++) begin
            btn_run = r; btn_step = s;
            ticks($urandom_range(1, DC - 1));
            btn_run = 1'b0; btn_step = 1'b0;
            ticks($urandom_range(1, 3));
        end
        btn_run = r; btn_step = s;
    endtask

    task automatic release_all();
        btn_run = 1'b0; btn_step = 1'b0;
        ticks(DC + 5);
    endtask

    task automatic watch_step(output int n_pos, output int lag, output bit done);
        int   p0;
        int   t_rise;
        logic prev;
        bit   went_low;
        p0 = cpu_pos; prev = clk_cpu; t_rise = -1; went_low = 0; done = 0; lag = -1;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            if (clk_cpu === 1'b1 && prev === 1'b0 && t_rise < 0) t_rise = c;
            prev = clk_cpu;
            if (stop === 1'b0) went_low = 1;
            else if (went_low) begin
                done = 1;
                lag = c - t_rise;
            end
        end
        ticks(10);
        n_pos = cpu_pos - p0;
    endtask

    task automatic test_reset();
        logic v0;
        bit   moved;
        rst_n = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        ticks(3);
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL reset_stop: got %b expected 1", stop); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", halted); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt); end
        #2 rst_n = 1'b1;
        tick();
        v0 = clk_cpu; moved = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clk_cpu !== v0) moved = 1;
        end
        checks++; if (moved) begin errors++; $display("FAIL reset_frozen: clk_cpu moved, expected frozen"); end
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL reset_stop_hold: got %b expected 1", stop); end
        m_mode = M_HALT; m_cnt = 0;
    endtask

    task automatic test_run_press();
        int p0;
        drive_press(1'b1, 1'b0, 0);
        ticks(6);
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL run_early: got stop=%b expected 1 at cycle 6", stop); end
        tick();
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL run_latency: got stop=%b expected 0 at cycle 7", stop); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_halted: got %b expected 0", halted); end
        p0 = cpu_pos;
        ticks(20);
        checks++; if (cpu_pos - p0 < 1) begin errors++; $display("FAIL run_toggle: got %0d posedges expected >=1", cpu_pos - p0); end
        release_all();
        drive_press(1'b1, 1'b0, $urandom_range(1, 3));
        ticks(7);
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL run_stop_again: got %b expected 1", stop); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL run_halt_again: got %b expected 1", halted); end
        release_all();
        m_mode = M_HALT;
    endtask

    task automatic test_step();
        int n_pos, lag, total;
        bit done;
        total = 0;
        for (int k = 0; k < 4; k++) begin
            drive_press(1'b0, 1'b1, (k == 0) ? 2 : $urandom_range(0, 3));
            watch_step(n_pos, lag, done);
            m_cnt++;
            total += n_pos;
            checks++; if (!done) begin errors++; $display("FAIL step%0d_done: stop never fell and returned within budget", k); end
            checks++; if (n_pos != 1) begin errors++; $display("FAIL step%0d_posedges: got %0d expected 1", k, n_pos); end
            checks++; if (lag < 1 || lag > 2) begin errors++; $display("FAIL step%0d_lag: got %0d expected 1..2", k, lag); end
            checks++; if (step_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL step%0d_cnt: got %0d expected %0d", k, step_cnt, 16'(m_cnt)); end
            checks++; if (step_cnt_w !== 2'(m_cnt)) begin errors++; $display("FAIL step%0d_wrapcnt: got %0d expected %0d", k, step_cnt_w, 2'(m_cnt)); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step%0d_halted: got %b expected 1", k, halted); end
            release_all();
        end
        checks++; if (total != 4) begin errors++; $display("FAIL step_total_posedges: got %0d expected 4", total); end
    endtask

    task automatic test_both();
        drive_press(1'b1, 1'b1, $urandom_range(0, 2));
        ticks(7);
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL both_stop: got %b expected 0", stop); end
        ticks(25);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL both_running: got halted=%b expected 0", halted); end
        checks++; if (step_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL both_cnt: got %0d expected %0d", step_cnt, 16'(m_cnt)); end
        release_all();
        m_mode = M_RUN;
    endtask

    task automatic test_step_in_run();
        drive_press(1'b0, 1'b1, $urandom_range(0, 3));
        ticks(30);
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL run_step_stop: got %b expected 0", stop); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_step_halted: got %b expected 0", halted); end
        checks++; if (step_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL run_step_cnt: got %0d expected %0d", step_cnt, 16'(m_cnt)); end
        release_all();
        drive_press(1'b1, 1'b0, 0);
        ticks(7);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL run_to_halt: got %b expected 1", halted); end
        release_all();
        m_mode = M_HALT;
    endtask

    task automatic test_step_abort();
        btn_step = 1'b1;
        tick();
        btn_run = 1'b1;
        ticks(7);
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL abort_in_step: got stop=%b expected 0", stop); end
        tick();
        ticks(25);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL abort_running: got halted=%b expected 0", halted); end
        checks++; if (step_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL abort_cnt: got %0d expected %0d", step_cnt, 16'(m_cnt)); end
        release_all();
        drive_press(1'b1, 1'b0, 0);
        ticks(7);
        release_all();
        m_mode = M_HALT;
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 2);
            drive_press(op != 1, op != 0, $urandom_range(0, 3));
            ticks(40);
            if (op != 1) m_mode = (m_mode == M_RUN) ? M_HALT : M_RUN;
            else if (m_mode == M_HALT) m_cnt++;
            checks++; if (halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rand%0d_halted: got %b expected %b (op %0d)", i, halted, m_mode == M_HALT, op); end
            checks++; if (stop !== (m_mode == M_HALT)) begin errors++; $display("FAIL rand%0d_stop: got %b expected %b (op %0d)", i, stop, m_mode == M_HALT, op); end
            checks++; if (step_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand%0d_cnt: got %0d expected %0d", i, step_cnt, 16'(m_cnt)); end
            checks++; if (step_cnt_w !== 2'(m_cnt) || halted_w !== halted) begin errors++; $display("FAIL rand%0d_narrow: got cnt=%0d halted=%b expected cnt=%0d halted=%b", i, step_cnt_w, halted_w, 2'(m_cnt), halted); end
            release_all();
        end
    endtask

    task automatic test_reset_mid_step();
        if (m_mode == M_RUN) begin
            drive_press(1'b1, 1'b0, 0);
            ticks(7);
            release_all();
            m_mode = M_HALT;
        end
        drive_press(1'b0, 1'b1, 0);
        ticks(8);
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL mid_step_active: got stop=%b expected 0", stop); end
        #2 rst_n = 1'b0;
        #1;
        m_cnt = 0;
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL mid_rst_stop: got %b expected 1", stop); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mid_rst_halted: got %b expected 1", halted); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", step_cnt); end
        checks++; if (step_cnt_w !== 2'd0 || stop_w !== 1'b1) begin errors++; $display("FAIL mid_rst_narrow: got cnt=%0d stop=%b expected 0,1", step_cnt_w, stop_w); end
        btn_step = 1'b0;
        ticks(3);
        #2 rst_n = 1'b1;
        ticks(20);
        checks++; if (halted !== 1'b1 || step_cnt !== 16'd0) begin errors++; $display("FAIL post_rst: got halted=%b cnt=%0d expected 1,0", halted, step_cnt); end
    endtask

    initial begin
        btn_run = 1'b0; btn_step = 1'b0; rst_n = 1'b0;
        m_mode = M_HALT; m_cnt = 0;
        test_reset();
        test_run_press();
        test_step();
        test_both();
        test_step_in_run();
        test_step_abort();
        test_random();
        test_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
